lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
Receive-side checker for the 8-bit LFSR byte stream produced by our random generator. Tap set: next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
- Self-synchronises by seeding its predictor from a received byte. Each byte carries the full LFSR state.
- Confirms lock after a run of correct predictions, then counts mismatches.
- Sits after the link/capture logic and feeds status LEDs or a debug register bank.

Parameters:
LOCK_COUNT, 4, consecutive correct predictions needed in SEARCH to declare lock (range 1..15)
LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock (range 1..15)
CNT_W, 16, width of error and byte counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
din_valid  input  1  din is valid this cycle; arbitrary gaps between valids allowed
din  input  8  received LFSR byte
clear_counts  input  1  synchronous clear of err_count and byte_count
locked  output  1  checker is in LOCKED state
match_pulse  output  1  one-cycle pulse: byte in LOCKED matched prediction
err_pulse  output  1  one-cycle pulse: byte in LOCKED mismatched prediction
zero_pulse  output  1  one-cycle pulse: all-zero byte received (illegal LFSR state)
err_count  output  CNT_W  saturating count of mismatches while LOCKED
byte_count  output  CNT_W  saturating count of din_valid bytes while LOCKED

Behaviour:
- Clock and reset: clk, rising edge; reset is synchronous, active-high.
- Reset state: all outputs 0, state IDLE, predictor 0, match/miss run counters 0.
- Next-state function: f(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
- Registered outputs: all outputs update on the clock edge after the din_valid cycle (latency 1). Pulses are high for exactly one cycle.
- No din_valid: no state, counter or predictor change, and all pulses are 0.
- State IDLE (no predictor):
  - valid, din==0: zero_pulse; stay IDLE.
  - valid, din!=0: pred<=f(din), match_run<=0; go to SEARCH.
- State SEARCH:
  - valid, din==pred: pred<=f(din), match_run++. If match_run+1==LOCK_COUNT: go to LOCKED, miss_run<=0.
  - valid, din!=pred, din!=0: reseed pred<=f(din), match_run<=0; stay SEARCH.
  - valid, din==0: zero_pulse; go to IDLE.
- State LOCKED (flywheel, never reseeds):
  - Every valid: byte_count++ (saturating); pred<=f(pred).
  - din==pred: match_pulse; miss_run<=0.
  - din!=pred: err_pulse; err_count++ (saturating); miss_run++. A zero byte also asserts zero_pulse and is counted as a mismatch.
  - If miss_run+1==LOSS_COUNT: drop lock. Go to SEARCH with pred<=f(din) and match_run<=0; if din==0, go to IDLE instead.
- locked equals (state==LOCKED), registered with the state.
- Counters:
  - Saturate at all-ones and do not wrap.
  - Change only in LOCKED; they hold across loss of lock.
- clear_counts:
  - Zeroes both counters on the next edge.
  - If asserted in the same cycle as a counted byte, clear wins and that byte's increments are dropped.
  - Does not affect state, predictor or pulses.
- Reset mid-stream: returns to IDLE regardless of state. Counters clear, and locked deasserts on the next edge.
- Reference sequence from seed 0x0D: 0D,1B,36,6C,D8,B1,63,C7.

Test Plan:
- Lock: after reset, feed valid 0D,1B,36,6C,D8 on consecutive cycles -> locked=0 through the D8 input cycle, then locked=1 one cycle later; err_count=0, byte_count=0.
- Single error: from lock, feed B0 (expected B1), then 63 -> err_pulse once, err_count=1, locked stays 1; 63 gives match_pulse (flywheel); byte_count=2.
- Loss of lock: from lock, feed 00,00,00 -> zero_pulse and err_pulse on each; locked falls after the third byte; state IDLE; err_count=3.
- Gaps and zero in IDLE: feed 00 then 0D, 1B with 5 idle cycles between valids -> zero_pulse on 00; no lock yet; outputs unchanged during gaps. Then 36,6C,D8 -> locked=1.
- Saturation and clear: CNT_W=2, locked, feed 5 wrong bytes interleaved with correct bytes (never LOSS_COUNT consecutive) -> err_count sticks at 3. Assert clear_counts in the same cycle as an error -> err_count=0.
- Reset mid-lock: assert reset for 1 cycle while locked -> locked=0, counters=0; the next non-zero byte reseeds from IDLE.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 8-bit LFSR byte stream.
// It seeds a predictor from one received byte, confirms lock after a run of
// correct predictions, and then flywheels the predictor while counting
// mismatches. Lock drops after a run of consecutive mismatches.
// All outputs are registered and appear one clock after the din_valid cycle.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT = 4,   // consecutive hits in SEARCH to lock (1..15)
    parameter int LOSS_COUNT = 3,   // consecutive misses in LOCKED to drop lock (1..15)
    parameter int CNT_W      = 16   // width of error and byte counters
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [7:0]       din,
    input  logic             clear_counts,
    output logic             locked,
    output logic             match_pulse,
    output logic             err_pulse,
    output logic             zero_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_COUNT);

    // Counter slots: 0 = mismatches while locked, 1 = bytes while locked.
    localparam int CNT_ERR  = 0;
    localparam int CNT_BYTE = 1;

    // Generator recurrence: shift left, feedback from taps 7,5,4,3 into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t      state_reg, state_next;
    logic [7:0]  pred_reg, pred_next;
    logic [3:0]  match_run_reg, match_run_next;
    logic [3:0]  miss_run_reg, miss_run_next;
    logic        match_pulse_reg, match_pulse_next;
    logic        err_pulse_reg, err_pulse_next;
    logic        zero_pulse_reg, zero_pulse_next;

    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       cnt_inc;

    logic din_is_zero;
    logic din_hit;

    assign din_is_zero = (din == 8'h00);
    assign din_hit     = (din == pred_reg);

    // State, predictor, run counters and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pred_reg        <= 8'h00;
            match_run_reg   <= 4'd0;
            miss_run_reg    <= 4'd0;
            match_pulse_reg <= 1'b0;
            err_pulse_reg   <= 1'b0;
            zero_pulse_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pred_reg        <= pred_next;
            match_run_reg   <= match_run_next;
            miss_run_reg    <= miss_run_next;
            match_pulse_reg <= match_pulse_next;
            err_pulse_reg   <= err_pulse_next;
            zero_pulse_reg  <= zero_pulse_next;
        end
    end

    // Next-state, predictor update and pulse/increment decisions.
    always_comb begin
        state_next       = state_reg;
        pred_next        = pred_reg;
        match_run_next   = match_run_reg;
        miss_run_next    = miss_run_reg;
        match_pulse_next = 1'b0;
        err_pulse_next   = 1'b0;
        zero_pulse_next  = 1'b0;
        cnt_inc          = 2'b00;

        if (din_valid) begin
            unique case (state_reg)
                IDLE: begin
                    if (din_is_zero) begin
                        zero_pulse_next = 1'b1;
                    end else begin
                        pred_next      = lfsr_next(din);
                        match_run_next = 4'd0;
                        state_next     = SEARCH;
                    end
                end

                SEARCH: begin
                    // The predictor is never zero here, so a zero byte can
                    // only be a miss; it drops back to IDLE rather than reseeding.
                    if (din_is_zero) begin
                        zero_pulse_next = 1'b1;
                        state_next      = IDLE;
                    end else if (din_hit) begin
                        pred_next      = lfsr_next(din);
                        match_run_next = match_run_reg + 4'd1;
                        if (match_run_reg + 4'd1 == LOCK_RUN) begin
                            state_next    = LOCKED;
                            miss_run_next = 4'd0;
                        end
                    end else begin
                        pred_next      = lfsr_next(din);
                        match_run_next = 4'd0;
                    end
                end

                LOCKED: begin
                    // Flywheel: the predictor advances on its own so a
                    // corrupted byte cannot pull the checker off-sequence.
                    cnt_inc[CNT_BYTE] = 1'b1;
                    pred_next         = lfsr_next(pred_reg);
                    if (din_hit) begin
                        match_pulse_next = 1'b1;
                        miss_run_next    = 4'd0;
                    end else begin
                        err_pulse_next   = 1'b1;
                        zero_pulse_next  = din_is_zero;
                        cnt_inc[CNT_ERR] = 1'b1;
                        miss_run_next    = miss_run_reg + 4'd1;
                        if (miss_run_reg + 4'd1 == LOSS_RUN) begin
                            miss_run_next  = 4'd0;
                            match_run_next = 4'd0;
                            if (din_is_zero) begin
                                state_next = IDLE;
                            end else begin
                                state_next = SEARCH;
                                pred_next  = lfsr_next(din);
                            end
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Saturating counters; a clear in the same cycle overrides the increment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset || clear_counts) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign locked      = (state_reg == LOCKED);
    assign match_pulse = match_pulse_reg;
    assign err_pulse   = err_pulse_reg;
    assign zero_pulse  = zero_pulse_reg;
    assign err_count   = cnt_reg[CNT_ERR];
    assign byte_count  = cnt_reg[CNT_BYTE];

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker. Two instances share the stimulus:
// one with 16-bit counters and one with 2-bit counters for saturation.
// The stimulus pushes one expected record per clock; a monitor pops and
// compares on the falling edge.
module tb_lfsr_seq_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       clear_counts = 1'b0;

    logic        locked_w, match_w, err_w, zero_w;
    logic [15:0] err_count_w, byte_count_w;
    logic        locked_n, match_n, err_n, zero_n;
    logic [1:0]  err_count_n, byte_count_n;

    always #5 clk = ~clk;

    lfsr_seq_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(16)) dut_w (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .clear_counts(clear_counts), .locked(locked_w), .match_pulse(match_w),
        .err_pulse(err_w), .zero_pulse(zero_w), .err_count(err_count_w),
        .byte_count(byte_count_w)
    );

    lfsr_seq_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .clear_counts(clear_counts), .locked(locked_n), .match_pulse(match_n),
        .err_pulse(err_n), .zero_pulse(zero_n), .err_count(err_count_n),
        .byte_count(byte_count_n)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [3:0] flags;   // {locked, match, err, zero}
        int         errc;    // unbounded counts; saturation applied at compare
        int         bytec;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- reference model ----------------
    // mode: 0 = no predictor, 1 = searching, 2 = locked
    int         m_mode;
    logic [7:0] m_pred;
    int         m_hits;
    int         m_misses;
    int         m_errc;
    int         m_bytec;
    logic [3:0] m_pulses;  // {match, err, zero} in bits [2:0]

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pred = 8'h00; m_hits = 0; m_misses = 0;
        m_errc = 0; m_bytec = 0; m_pulses = 4'h0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        logic hit;
        m_pulses = 4'h0;
        if (v) begin
            if (m_mode == 0) begin
                if (d == 8'h00) m_pulses[0] = 1'b1;
                else begin m_mode = 1; m_pred = lfsr_next(d); m_hits = 0; end
            end else if (m_mode == 1) begin
                if (d == 8'h00) begin m_pulses[0] = 1'b1; m_mode = 0; end
                else if (d == m_pred) begin
                    m_hits++;
                    m_pred = lfsr_next(d);
                    if (m_hits == LOCK_N) begin m_mode = 2; m_misses = 0; end
                end else begin m_pred = lfsr_next(d); m_hits = 0; end
            end else begin
                hit = (d == m_pred);
                m_bytec++;
                m_pred = lfsr_next(m_pred);
                if (hit) begin m_pulses[2] = 1'b1; m_misses = 0; end
                else begin
                    m_pulses[1] = 1'b1;
                    m_pulses[0] = (d == 8'h00);
                    m_errc++;
                    m_misses++;
                    if (m_misses == LOSS_N) begin
                        m_hits = 0; m_misses = 0;
                        if (d == 8'h00) m_mode = 0;
                        else begin m_mode = 1; m_pred = lfsr_next(d); end
                    end
                end
            end
        end
        if (clr) begin m_errc = 0; m_bytec = 0; end
    endtask

    task automatic push_exp(input logic v, input logic [7:0] d);
        exp_t e;
        e.valid = v;
        e.data  = d;
        e.flags = {(m_mode == 2), m_pulses[2:0]};
        e.errc  = m_errc;
        e.bytec = m_bytec;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic v, input logic [7:0] d, input logic clr);
        reset = 1'b0; din_valid = v; din = d; clear_counts = clr;
        @(posedge clk);
        model_step(v, d, clr);
        push_exp(v, d);
        #1;
        din_valid = 1'b0; clear_counts = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; din_valid = 1'b0; clear_counts = 1'b0;
        @(posedge clk);
        model_reset();
        push_exp(1'b0, 8'h00);
        #1;
        reset = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    // Feed n consecutive stream bytes starting at s; returns the next stream byte.
    task automatic stream(input logic [7:0] s, input int n, output logic [7:0] nxt);
        logic [7:0] x;
        x = s;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, x, 1'b0);
            x = lfsr_next(x);
        end
        nxt = x;
    endtask

    function automatic logic [7:0] corrupt(input logic [7:0] x);
        logic [7:0] y;
        y = x ^ 8'h01;
        if (y == 8'h00) y = x ^ 8'h02;
        return y;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] ew, bw;
            logic [1:0]  en, bn;
            e  = exp_q.pop_front();
            ew = (e.errc  > 65535) ? 16'hFFFF : 16'(e.errc);
            bw = (e.bytec > 65535) ? 16'hFFFF : 16'(e.bytec);
            en = (e.errc  > 3) ? 2'd3 : 2'(e.errc);
            bn = (e.bytec > 3) ? 2'd3 : 2'(e.bytec);
            if (e.valid)
                $display("[TB] t=%0t byte %02h -> locked=%0b match=%0b err=%0b zero=%0b errc=%0d bytes=%0d",
                         $time, e.data, locked_w, match_w, err_w, zero_w, err_count_w, byte_count_w);
            n_tests++;
            if ({locked_w, match_w, err_w, zero_w} !== e.flags) begin
                n_fail++;
                $display("FAIL flags_w t=%0t got %04b want %04b", $time,
                         {locked_w, match_w, err_w, zero_w}, e.flags);
            end
            n_tests++;
            if ({err_count_w, byte_count_w} !== {ew, bw}) begin
                n_fail++;
                $display("FAIL counts_w t=%0t got err=%0d bytes=%0d want err=%0d bytes=%0d",
                         $time, err_count_w, byte_count_w, ew, bw);
            end
            n_tests++;
            if ({locked_n, match_n, err_n, zero_n} !== e.flags) begin
                n_fail++;
                $display("FAIL flags_n t=%0t got %04b want %04b", $time,
                         {locked_n, match_n, err_n, zero_n}, e.flags);
            end
            n_tests++;
            if ({err_count_n, byte_count_n} !== {en, bn}) begin
                n_fail++;
                $display("FAIL counts_n t=%0t got err=%0d bytes=%0d want err=%0d bytes=%0d",
                         $time, err_count_n, byte_count_n, en, bn);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] nx;
        logic [7:0] g;
        model_reset();

        // Reset state, then lock on the reference sequence.
        do_reset();
        stream(8'h0D, 5, nx);              // 0D,1B,36,6C,D8 -> locked
        // Single error then flywheel match.
        cyc(1'b1, 8'hB0, 1'b0);            // expected B1
        cyc(1'b1, 8'h63, 1'b0);            // flywheel hit
        // Loss of lock through three zero bytes.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        gap(2);

        // Zero in IDLE, gaps between valids, then lock.
        do_reset();
        cyc(1'b1, 8'h00, 1'b0);
        gap(5);
        cyc(1'b1, 8'h0D, 1'b0);
        gap(5);
        cyc(1'b1, 8'h1B, 1'b0);
        gap(5);
        stream(8'h36, 3, nx);              // 36,6C,D8 -> locked

        // Saturation: five errors interleaved with hits, then clear with an error.
        g = nx;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, corrupt(g), 1'b0); g = lfsr_next(g);
            cyc(1'b1, g, 1'b0);          g = lfsr_next(g);
        end
        cyc(1'b1, corrupt(g), 1'b1);       g = lfsr_next(g);
        cyc(1'b1, g, 1'b0);                g = lfsr_next(g);

        // Reset mid-lock, then reseed from IDLE.
        do_reset();
        stream(8'hA5, 6, nx);
        gap(2);

        // Randomised traffic: mostly-correct stream with corruptions,
        // zeros, gaps, resyncs, clears and occasional resets.
        g = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3000; i++) begin
            int r, k;
            logic [7:0] d;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else if (r < 60) begin
                cyc(1'b0, 8'($urandom_range(0, 255)), ($urandom_range(0, 49) == 0));
            end else begin
                k = $urandom_range(0, 99);
                if (k < 85)      d = g;
                else if (k < 90) d = 8'h00;
                else             d = 8'($urandom_range(0, 255));
                cyc(1'b1, d, ($urandom_range(0, 49) == 0));
                g = lfsr_next(g);
                if ($urandom_range(0, 299) == 0) g = 8'($urandom_range(1, 255));
            end
        end

        gap(2);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
